// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA mode constants, derived-timing helpers and colour-word type
package vga_pkg;
  localparam int VGA_640X480_H_SYNC = 96;
  localparam int VGA_640X480_H_BP = 48;
  localparam int VGA_640X480_H_ACTIVE = 640;
  localparam int VGA_640X480_H_FP = 16;
  localparam int VGA_640X480_V_SYNC = 2;
  localparam int VGA_640X480_V_BP = 33;
  localparam int VGA_640X480_V_ACTIVE = 480;
  localparam int VGA_640X480_V_FP = 10;
  localparam int VGA_800X600_H_SYNC = 128;
  localparam int VGA_800X600_H_BP = 88;
  localparam int VGA_800X600_H_ACTIVE = 800;
  localparam int VGA_800X600_H_FP = 40;
  localparam int VGA_800X600_V_SYNC = 4;
  localparam int VGA_800X600_V_BP = 23;
  localparam int VGA_800X600_V_ACTIVE = 600;
  localparam int VGA_800X600_V_FP = 1;
  localparam int VGA_CW = 4;
  typedef logic [3*VGA_CW-1:0] rgb_t;
  function automatic int timing_total(input int sync, input int bp, input int act, input int fp);
    return sync + bp + act + fp;
  endfunction
  function automatic int timing_start(input int sync, input int bp);
    return sync + bp;
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage W-bit shift register with sync clear (vga_clk, clr, d -> q)
module vga_delay_line #(
  parameter int DEPTH = 1,
  parameter int W = 1
) (
  input  logic         vga_clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [DEPTH];
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/vgac_param.sv
// vgac_param: parametrised VGA timing with RAM addressing (row/col_addr, rdn), latency-aligned rgb/hs/vs/de/sof/eol and frame_cnt
module vgac_param import vga_pkg::*; #(
  parameter int H_SYNC = VGA_640X480_H_SYNC,
  parameter int H_BP = VGA_640X480_H_BP,
  parameter int H_ACTIVE = VGA_640X480_H_ACTIVE,
  parameter int H_FP = VGA_640X480_H_FP,
  parameter int V_SYNC = VGA_640X480_V_SYNC,
  parameter int V_BP = VGA_640X480_V_BP,
  parameter int V_ACTIVE = VGA_640X480_V_ACTIVE,
  parameter int V_FP = VGA_640X480_V_FP,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int SCALE = 0,
  parameter int FETCH_LAT = 1,
  parameter int CW = VGA_CW,
  parameter logic [3*CW-1:0] BLANK_RGB = '0
) (
  input  logic                        vga_clk,
  input  logic                        clr,
  input  logic [3*CW-1:0]             d_in,
  output logic [$clog2(V_ACTIVE)-1:0] row_addr,
  output logic [$clog2(H_ACTIVE)-1:0] col_addr,
  output logic                        rdn,
  output logic [CW-1:0]               r,
  output logic [CW-1:0]               g,
  output logic [CW-1:0]               b,
  output logic                        hs,
  output logic                        vs,
  output logic                        de,
  output logic                        sof,
  output logic                        eol,
  output logic [15:0]                 frame_cnt
);
  localparam int H_TOTAL = timing_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = timing_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int H_START = timing_start(H_SYNC, H_BP);
  localparam int V_START = timing_start(V_SYNC, V_BP);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int CAW = $clog2(H_ACTIVE);
  localparam int RAW = $clog2(V_ACTIVE);
  if (FETCH_LAT < 1 || FETCH_LAT > 4) begin : g_lat_chk
    $error("vgac_param: FETCH_LAT must be 1..4");
  end
  if (H_SYNC < 1 || H_BP < 1 || H_FP < 1 || V_SYNC < 1 || V_BP < 1 || V_FP < 1) begin : g_porch_chk
    $error("vgac_param: sync and porch widths must be non-zero");
  end
  logic [HW-1:0] h_count, h_off;
  logic [VW-1:0] v_count, v_off;
  logic h_end, v_end, act;
  logic [4:0] ctrl, s1_ctrl, dl_ctrl;
  always_comb begin
    h_end = h_count == HW'(H_TOTAL - 1);
    v_end = v_count == VW'(V_TOTAL - 1);
    act = h_count >= HW'(H_START) && h_count < HW'(H_START + H_ACTIVE)
       && v_count >= VW'(V_START) && v_count < VW'(V_START + V_ACTIVE);
    h_off = h_count - HW'(H_START);
    v_off = v_count - VW'(V_START);
    ctrl = {act, h_count < HW'(H_SYNC), v_count < VW'(V_SYNC),
            act && h_count == HW'(H_START) && v_count == VW'(V_START),
            act && h_count == HW'(H_START + H_ACTIVE - 1)};
  end
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      h_count <= '0;
      v_count <= '0;
      frame_cnt <= '0;
    end else begin
      h_count <= h_end ? '0 : h_count + 1'b1;
      if (h_end) v_count <= v_end ? '0 : v_count + 1'b1;
      if (h_end && v_end) frame_cnt <= frame_cnt + 1'b1;
    end
  end
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      rdn <= 1'b1;
      col_addr <= '0;
      row_addr <= '0;
      s1_ctrl <= '0;
    end else begin
      rdn <= ~act;
      col_addr <= act ? CAW'(h_off >> SCALE) : '0;
      row_addr <= act ? RAW'(v_off >> SCALE) : '0;
      s1_ctrl <= ctrl;
    end
  end
  vga_delay_line #(.DEPTH(FETCH_LAT), .W(5)) u_dly (
    .vga_clk(vga_clk),
    .clr(clr),
    .d(s1_ctrl),
    .q(dl_ctrl)
  );
  always_ff @(posedge vga_clk) begin
    if (clr) begin
      de <= 1'b0;
      sof <= 1'b0;
      eol <= 1'b0;
      {b, g, r} <= BLANK_RGB;
      hs <= ~HS_POL;
      vs <= ~VS_POL;
    end else begin
      de <= dl_ctrl[4];
      sof <= dl_ctrl[1];
      eol <= dl_ctrl[0];
      {b, g, r} <= dl_ctrl[4] ? d_in : BLANK_RGB;
      hs <= dl_ctrl[3] ? HS_POL : ~HS_POL;
      vs <= dl_ctrl[2] ? VS_POL : ~VS_POL;
    end
  end
endmodule
